sipo_rx: RTL and testbench

SIPO_RX -- requirements
Module: sipo_rx

---
 rtl/sipo_rx.sv | 129 ++++++++++++
 tb/tb_sipo_rx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
//------------------------------------------------------------------------------
// Module   : sipo_rx
// Brief    : Framed serial-in/parallel-out receiver (MSB first) with a
//            one-word output register, ready/valid handshake and sticky
//            overrun. Optional even parity via macro SIPO_RX_PARITY_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sipo_rx #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             serial_in,
   input  logic             shift_en,
   input  logic             start,
   input  logic             out_ready,
   input  logic             ovr_clr,
   output logic [WIDTH-1:0] parallel_out,
   output logic             valid,
   output logic             busy,
   output logic             overrun,
   output logic             parity_err
);

`ifdef SIPO_RX_PARITY_EN
   localparam int c_par_bits = 1;
`else
   localparam int c_par_bits = 0;
`endif
   localparam int c_fl = WIDTH + c_par_bits;
   localparam int c_cw = $clog2(c_fl + 1);
   localparam logic [c_cw-1:0] c_last = c_cw'(c_fl - 1);

   localparam logic [0:0] c_st_idle  = 1'b0;
   localparam logic [0:0] c_st_shift = 1'b1;

   logic [0:0]       r_state;
   logic [c_cw-1:0]  r_cnt;
   logic [c_fl-1:0]  r_sr;
   logic [WIDTH-1:0] r_parallel;
   logic             r_valid;
   logic             r_overrun;

   logic [c_fl-1:0]  w_frame;
   logic [WIDTH-1:0] w_data;
   logic             w_restart;
   logic             w_shift;
   logic             w_done;
   logic             w_accept;
   logic             w_drop;

   // Frame as it stands once the current bit is included; data bits lead.
   assign w_frame   = {r_sr[c_fl-2:0], serial_in};
   assign w_data    = w_frame[c_fl-1 -: WIDTH];
   assign w_restart = shift_en & start;
   assign w_shift   = shift_en & ~start & (r_state == c_st_shift);
   assign w_done    = w_shift & (r_cnt == c_last);
   assign w_accept  = w_done & (~r_valid | out_ready);
   assign w_drop    = w_done & r_valid & ~out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_st_idle;
         r_cnt   <= '0;
         r_sr    <= '0;
      end else if (w_restart) begin
         // Start also aborts any partial frame in progress.
         r_state <= c_st_shift;
         r_cnt   <= c_cw'(1);
         r_sr    <= {{(c_fl-1){1'b0}}, serial_in};
      end else if (w_done) begin
         r_state <= c_st_idle;
         r_cnt   <= '0;
         r_sr    <= w_frame;
      end else if (w_shift) begin
         r_cnt   <= r_cnt + c_cw'(1);
         r_sr    <= w_frame;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_parallel <= '0;
         r_valid    <= 1'b0;
      end else if (w_accept) begin
         r_parallel <= w_data;
         r_valid    <= 1'b1;
      end else if (r_valid && out_ready) begin
         r_valid    <= 1'b0;
      end
   end

   // A drop on the same edge as a clear wins so no overrun is lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overrun <= 1'b0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
      end else if (ovr_clr) begin
         r_overrun <= 1'b0;
      end
   end

`ifdef SIPO_RX_PARITY_EN
   logic r_parity_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_parity_err <= 1'b0;
      end else if (w_accept) begin
         r_parity_err <= ^w_frame;
      end
   end

   assign parity_err = r_parity_err;
`else
   assign parity_err = 1'b0;
`endif

   assign parallel_out = r_parallel;
   assign valid        = r_valid;
   assign busy         = (r_state == c_st_shift);
   assign overrun      = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_sipo_rx.sv
//------------------------------------------------------------------------------
// Module   : tb_sipo_rx
// Brief    : Directed self-checking bench for sipo_rx (WIDTH=4); parity
//            scenario active when SIPO_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sipo_rx;

   localparam int WIDTH = 4;
`ifdef SIPO_RX_PARITY_EN
   localparam int FL = WIDTH + 1;
`else
   localparam int FL = WIDTH;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             serial_in = 1'b0;
   logic             shift_en = 1'b0;
   logic             start = 1'b0;
   logic             out_ready = 1'b0;
   logic             ovr_clr = 1'b0;
   logic [WIDTH-1:0] parallel_out;
   logic             valid;
   logic             busy;
   logic             overrun;
   logic             parity_err;

   int checks = 0;
   int errors = 0;

   sipo_rx #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .serial_in    (serial_in),
      .shift_en     (shift_en),
      .start        (start),
      .out_ready    (out_ready),
      .ovr_clr      (ovr_clr),
      .parallel_out (parallel_out),
      .valid        (valid),
      .busy         (busy),
      .overrun      (overrun),
      .parity_err   (parity_err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] frame_of(input logic [WIDTH-1:0] d);
`ifdef SIPO_RX_PARITY_EN
      return {3'b000, d, ^d};
`else
      return {4'b0000, d};
`endif
   endfunction

   task automatic send_bit(input logic b, input logic st);
      serial_in = b;
      start     = st;
      shift_en  = 1'b1;
      @(posedge clk);
      #1;
      shift_en  = 1'b0;
      start     = 1'b0;
      serial_in = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [WIDTH-1:0] d);
      logic [7:0] f;
      f = frame_of(d);
      for (int i = FL - 1; i >= 0; i--) send_bit(f[i], i == FL - 1);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      idle_cycle();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (parallel_out !== 4'b0000) begin errors++; $display("FAIL reset_po got %b exp 0000", parallel_out); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
      checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity got %b exp 0", parity_err); end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      idle_cycle();
   endtask

   task automatic test_basic();
      logic [7:0] f;
      f = frame_of(4'b1011);
      for (int i = FL - 1; i >= 0; i--) begin
         send_bit(f[i], i == FL - 1);
         if (i > 0) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy bit %0d got %b exp 1", FL - i, busy); end
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_novalid bit %0d got %b exp 0", FL - i, valid); end
         end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b exp 0", busy); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", valid); end
      checks++; if (parallel_out !== 4'b1011) begin errors++; $display("FAIL basic_po got %b exp 1011", parallel_out); end
      checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL basic_parity got %b exp 0", parity_err); end
      consume();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_consume got %b exp 0", valid); end
      checks++; if (parallel_out !== 4'b1011) begin errors++; $display("FAIL basic_po_hold got %b exp 1011", parallel_out); end
   endtask

   task automatic test_gapped();
      logic [7:0] f;
      f = frame_of(4'b1011);
      for (int i = FL - 1; i >= 0; i--) begin
         send_bit(f[i], i == FL - 1);
         idle_cycle();
         if (i > 0) begin
            checks++; if (busy !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL gapped_hold bit %0d got busy %b valid %b exp 1 0", FL - i, busy, valid); end
         end
      end
      checks++; if (busy !== 1'b0 || valid !== 1'b1) begin errors++; $display("FAIL gapped_end got busy %b valid %b exp 0 1", busy, valid); end
      checks++; if (parallel_out !== 4'b1011) begin errors++; $display("FAIL gapped_po got %b exp 1011", parallel_out); end
      consume();
   endtask

   task automatic test_overrun();
      send_word(4'b1011);
      checks++; if (valid !== 1'b1 || parallel_out !== 4'b1011) begin errors++; $display("FAIL ovr_first got valid %b po %b exp 1 1011", valid, parallel_out); end
      send_word(4'b0110);
      checks++; if (parallel_out !== 4'b1011) begin errors++; $display("FAIL ovr_po got %b exp 1011", parallel_out); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", overrun); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", valid); end
      ovr_clr = 1'b1;
      idle_cycle();
      ovr_clr = 1'b0;
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got %b exp 0", overrun); end
      // clear held on the same edge as a new drop: drop wins
      ovr_clr = 1'b1;
      send_word(4'b0001);
      ovr_clr = 1'b0;
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_same_edge got %b exp 1", overrun); end
      checks++; if (parallel_out !== 4'b1011) begin errors++; $display("FAIL ovr_po2 got %b exp 1011", parallel_out); end
      ovr_clr = 1'b1;
      idle_cycle();
      ovr_clr = 1'b0;
      consume();
      checks++; if (valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_final got valid %b ovr %b exp 0 0", valid, overrun); end
      checks++; if (parallel_out !== 4'b1011) begin errors++; $display("FAIL ovr_po_keep got %b exp 1011", parallel_out); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] f;
      out_ready = 1'b1;
      send_word(4'b1011);
      checks++; if (valid !== 1'b1 || parallel_out !== 4'b1011) begin errors++; $display("FAIL b2b_first got valid %b po %b exp 1 1011", valid, parallel_out); end
      send_word(4'b0101);
      checks++; if (valid !== 1'b1 || parallel_out !== 4'b0101) begin errors++; $display("FAIL b2b_second got valid %b po %b exp 1 0101", valid, parallel_out); end
      out_ready = 1'b0;
      idle_cycle();
      // completion while valid=1 but ready on that edge: loads, no overrun
      f = frame_of(4'b1110);
      for (int i = FL - 1; i >= 0; i--) begin
         if (i == 0) out_ready = 1'b1;
         send_bit(f[i], i == FL - 1);
      end
      out_ready = 1'b0;
      checks++; if (parallel_out !== 4'b1110 || valid !== 1'b1) begin errors++; $display("FAIL b2b_ready_load got po %b valid %b exp 1110 1", parallel_out, valid); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_no_ovr got %b exp 0", overrun); end
      consume();
   endtask

   task automatic test_abort();
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b0);
      send_word(4'b0110);
      checks++; if (valid !== 1'b1 || parallel_out !== 4'b0110) begin errors++; $display("FAIL abort_po got valid %b po %b exp 1 0110", valid, parallel_out); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL abort_no_ovr got %b exp 0", overrun); end
      consume();
      // two-bit partial then a full restart: nothing delivered in between
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b1);
      checks++; if (valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL abort_mid got valid %b busy %b exp 0 1", valid, busy); end
      consume();
      send_bit(1'b0, 1'b0);
   endtask

   task automatic test_reset_midframe();
      // leave the receiver idle, then load a word and start a frame
      send_word(4'b0000);
      consume();
      send_word(4'b1011);
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      checks++; if (parallel_out !== 4'b0000 || valid !== 1'b0) begin errors++; $display("FAIL rstmid_out got po %b valid %b exp 0000 0", parallel_out, valid); end
      checks++; if (busy !== 1'b0 || overrun !== 1'b0 || parity_err !== 1'b0) begin errors++; $display("FAIL rstmid_flags got busy %b ovr %b par %b exp 0 0 0", busy, overrun, parity_err); end
      #3;
      rst = 1'b0;
      idle_cycle();
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle got busy %b valid %b exp 0 0", busy, valid); end
      send_word(4'b1100);
      checks++; if (parallel_out !== 4'b1100 || valid !== 1'b1) begin errors++; $display("FAIL rstmid_frame got po %b valid %b exp 1100 1", parallel_out, valid); end
      consume();
   endtask

`ifdef SIPO_RX_PARITY_EN
   task automatic test_parity();
      logic [4:0] a;
      logic [4:0] b;
      a = 5'b10111;
      b = 5'b10110;
      for (int i = 4; i >= 0; i--) send_bit(a[i], i == 4);
      checks++; if (parallel_out !== 4'b1011 || parity_err !== 1'b0) begin errors++; $display("FAIL parity_good got po %b pe %b exp 1011 0", parallel_out, parity_err); end
      consume();
      for (int i = 4; i >= 0; i--) send_bit(b[i], i == 4);
      checks++; if (parallel_out !== 4'b1011 || parity_err !== 1'b1 || valid !== 1'b1) begin errors++; $display("FAIL parity_bad got po %b pe %b valid %b exp 1011 1 1", parallel_out, parity_err, valid); end
      consume();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_gapped();
      test_overrun();
      test_back_to_back();
      test_abort();
      test_reset_midframe();
`ifdef SIPO_RX_PARITY_EN
      test_parity();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
